// File: rtl/save_slot_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : save_slot_controller_if
// Brief    : Request/handshake bundle between the key inputs, the save
//            manager and the board engine for save_slot_controller.
// Revision : 1.0 - initial release
// ============================================================================
interface save_slot_controller_if;
    logic [3:0]  slot_sel;
    logic        save_req;
    logic        load_req;
    logic        sim_idle;
    logic        sim_pause;
    logic [3:0]  ram_addr;
    logic        ram_wren;
    logic        board_load;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] slot_valid;

    // Controller side
    modport slave (
        input  slot_sel, save_req, load_req, sim_idle,
        output sim_pause, ram_addr, ram_wren, board_load, busy, err, err_code,
               slot_valid
    );

    // Requester / environment side
    modport master (
        output slot_sel, save_req, load_req, sim_idle,
        input  sim_pause, ram_addr, ram_wren, board_load, busy, err, err_code,
               slot_valid
    );
endinterface
`default_nettype wire

// File: rtl/save_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : save_slot_controller
// Brief    : Pauses the engine, then issues a one-cycle slot write or a timed
//            slot read followed by a board-load strobe; tracks valid slots.
// Revision : 1.0 - initial release
// ============================================================================
module save_slot_controller #(
    parameter int          READ_LATENCY  = 2,
    parameter logic [15:0] PRESET_MASK   = 16'h801F,
    parameter int          PAUSE_TIMEOUT = 255
) (
    input  wire                   clk,
    input  wire                   rst,
    save_slot_controller_if.slave bus
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PAUSE      = 3'd1;
    localparam logic [2:0] S_SAVE_WR    = 3'd2;
    localparam logic [2:0] S_LOAD_WAIT  = 3'd3;
    localparam logic [2:0] S_LOAD_APPLY = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [1:0] c_ERR_PRESET  = 2'd1;
    localparam logic [1:0] c_ERR_EMPTY   = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(PAUSE_TIMEOUT - 1);
    localparam logic [15:0] c_READ_LAST    = 16'(READ_LATENCY - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_cnt;
    logic        r_is_save;
    logic [3:0]  r_ram_addr;
    logic [15:0] r_ram_valid;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_err_set;
    logic [1:0]  w_err_code_next;
    logic [15:0] w_slot_valid;

    logic        w_sim_pause;
    logic        w_ram_wren;
    logic        w_board_load;
    logic        w_busy;

    assign w_slot_valid = PRESET_MASK | r_ram_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and request acceptance
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_err_set       = 1'b0;
        w_err_code_next = r_err_code;
        case (r_state)
            S_IDLE: begin
                // Save has priority; a simultaneous load is dropped.
                if (bus.save_req) begin
                    if (PRESET_MASK[bus.slot_sel]) begin
                        w_err_set       = 1'b1;
                        w_err_code_next = c_ERR_PRESET;
                    end else begin
                        w_state_next = S_PAUSE;
                    end
                end else if (bus.load_req) begin
                    if (!w_slot_valid[bus.slot_sel]) begin
                        w_err_set       = 1'b1;
                        w_err_code_next = c_ERR_EMPTY;
                    end else begin
                        w_state_next = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.sim_idle) begin
                    w_state_next = r_is_save ? S_SAVE_WR : S_LOAD_WAIT;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_next    = S_DONE;
                    w_err_set       = 1'b1;
                    w_err_code_next = c_ERR_TIMEOUT;
                end
            end
            S_SAVE_WR: begin
                w_state_next = S_DONE;
            end
            S_LOAD_WAIT: begin
                if (r_cnt == c_READ_LAST) begin
                    w_state_next = S_LOAD_APPLY;
                end
            end
            S_LOAD_APPLY: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: slot latch, cycle counter, valid bits, error reporting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 16'd0;
            r_is_save   <= 1'b0;
            r_ram_addr  <= 4'd0;
            r_ram_valid <= 16'd0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_err <= w_err_set;
            if (w_err_set) begin
                r_err_code <= w_err_code_next;
            end
            // Address tracks the switches only while idle, freezing on accept.
            if (r_state == S_IDLE) begin
                r_ram_addr <= bus.slot_sel;
                if (w_state_next == S_PAUSE) begin
                    r_is_save <= bus.save_req;
                end
            end
            if (r_state != w_state_next) begin
                r_cnt <= 16'd0;
            end else if (r_state == S_PAUSE || r_state == S_LOAD_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == S_SAVE_WR) begin
                r_ram_valid[r_ram_addr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        w_sim_pause  = 1'b0;
        w_ram_wren   = 1'b0;
        w_board_load = 1'b0;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_PAUSE, S_LOAD_WAIT: begin
                w_sim_pause = 1'b1;
            end
            S_SAVE_WR: begin
                w_sim_pause = 1'b1;
                // A reset arriving mid-write must not reach the RAM.
                w_ram_wren  = !rst;
            end
            S_LOAD_APPLY: begin
                w_sim_pause  = 1'b1;
                w_board_load = !rst;
            end
            default: begin
                w_sim_pause = 1'b0;
            end
        endcase
    end

    assign bus.sim_pause  = w_sim_pause;
    assign bus.ram_wren   = w_ram_wren;
    assign bus.board_load = w_board_load;
    assign bus.busy       = w_busy;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.slot_valid = w_slot_valid;

endmodule
`default_nettype wire

// File: tb/tb_save_slot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_save_slot_controller
// Brief    : Directed self-checking bench for save_slot_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_save_slot_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    save_slot_controller_if bus ();

    save_slot_controller #(
        .READ_LATENCY  (2),
        .PRESET_MASK   (16'h801F),
        .PAUSE_TIMEOUT (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.slot_sel = 4'd0;
        bus.save_req = 1'b0;
        bus.load_req = 1'b0;
        bus.sim_idle = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.busy, bus.sim_pause, bus.ram_wren, bus.board_load, bus.err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.busy, bus.sim_pause, bus.ram_wren, bus.board_load, bus.err});
        end
        n_checks++;
        if (bus.err_code !== 2'd0 || bus.ram_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_code_addr got=%0d/%0d want=0/0", bus.err_code, bus.ram_addr);
        end
        n_checks++;
        if (bus.slot_valid !== 16'h801F) begin
            n_fail++;
            $display("FAIL reset_valid got=%h want=801f", bus.slot_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_empty();
        bus.slot_sel = 4'd7;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 2'd2 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_empty err/code/busy got=%b/%0d/%b want=1/2/0",
                     bus.err, bus.err_code, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.err !== 1'b0 || bus.err_code !== 2'd2 || bus.slot_valid !== 16'h801F) begin
            n_fail++;
            $display("FAIL load_empty_after err/code/valid got=%b/%0d/%h want=0/2/801f",
                     bus.err, bus.err_code, bus.slot_valid);
        end
    endtask

    task automatic test_save();
        bus.sim_idle = 1'b1;
        bus.slot_sel = 4'd7;
        bus.save_req = 1'b1;
        tick();                                   // T+1
        bus.save_req = 1'b0;
        n_checks++;
        if (bus.sim_pause !== 1'b1 || bus.busy !== 1'b1 || bus.ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL save_t1 pause/busy/wren got=%b/%b/%b want=1/1/0",
                     bus.sim_pause, bus.busy, bus.ram_wren);
        end
        tick();                                   // T+2
        n_checks++;
        if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 4'd7 || bus.sim_pause !== 1'b1) begin
            n_fail++;
            $display("FAIL save_t2 wren/addr/pause got=%b/%0d/%b want=1/7/1",
                     bus.ram_wren, bus.ram_addr, bus.sim_pause);
        end
        tick();                                   // T+3
        n_checks++;
        if (bus.ram_wren !== 1'b0 || bus.slot_valid !== 16'h809F || bus.busy !== 1'b1
            || bus.sim_pause !== 1'b0) begin
            n_fail++;
            $display("FAIL save_t3 wren/valid/busy/pause got=%b/%h/%b/%b want=0/809f/1/0",
                     bus.ram_wren, bus.slot_valid, bus.busy, bus.sim_pause);
        end
        tick();                                   // T+4
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL save_t4 busy got=%b want=0", bus.busy);
        end
    endtask

    task automatic test_load();
        bus.sim_idle = 1'b1;
        bus.slot_sel = 4'd7;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        bus.slot_sel = 4'd2;                      // must not disturb the frozen address
        for (int k = 1; k <= 6; k++) begin
            n_checks++;
            if (bus.board_load !== (k == 4) || bus.ram_wren !== 1'b0
                || bus.ram_addr !== 4'd7 || bus.busy !== (k < 6)) begin
                n_fail++;
                $display("FAIL load_t%0d load/wren/addr/busy got=%b/%b/%0d/%b want=%b/0/7/%b",
                         k, bus.board_load, bus.ram_wren, bus.ram_addr, bus.busy,
                         (k == 4), (k < 6));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int n_wren;
        int n_load;
        n_wren = 0;
        n_load = 0;
        bus.sim_idle = 1'b1;
        bus.slot_sel = 4'd9;
        bus.save_req = 1'b1;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        bus.slot_sel = 4'd5;                      // second save while busy is ignored
        for (int k = 1; k <= 8; k++) begin
            if (bus.ram_wren) begin
                n_wren++;
                n_checks++;
                if (bus.ram_addr !== 4'd9) begin
                    n_fail++;
                    $display("FAIL b2b_addr got=%0d want=9", bus.ram_addr);
                end
            end
            if (bus.board_load) n_load++;
            tick();
            bus.save_req = 1'b0;
        end
        n_checks++;
        if (n_wren != 1 || n_load != 0) begin
            n_fail++;
            $display("FAIL b2b_counts wren=%0d load=%0d want=1/0", n_wren, n_load);
        end
        n_checks++;
        if (bus.slot_valid !== 16'h829F || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_valid valid/busy got=%h/%b want=829f/0", bus.slot_valid, bus.busy);
        end
    endtask

    task automatic test_preset_save();
        bus.slot_sel = 4'd0;
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 2'd1 || bus.sim_pause !== 1'b0
            || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL preset_save err/code/pause/busy got=%b/%0d/%b/%b want=1/1/0/0",
                     bus.err, bus.err_code, bus.sim_pause, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.sim_pause !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL preset_after pause/err got=%b/%b want=0/0", bus.sim_pause, bus.err);
        end
    endtask

    task automatic test_timeout();
        int n_load;
        n_load = 0;
        bus.sim_idle = 1'b0;
        bus.slot_sel = 4'd15;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (bus.sim_pause !== 1'b1 || bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_pause_t%0d pause/err got=%b/%b want=1/0",
                         k, bus.sim_pause, bus.err);
            end
            if (bus.board_load) n_load++;
            tick();
        end
        n_checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 2'd3 || bus.sim_pause !== 1'b0
            || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_t5 err/code/pause/busy got=%b/%0d/%b/%b want=1/3/0/1",
                     bus.err, bus.err_code, bus.sim_pause, bus.busy);
        end
        if (bus.board_load) n_load++;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0 || n_load != 0) begin
            n_fail++;
            $display("FAIL timeout_t6 busy/err/loads got=%b/%b/%0d want=0/0/0",
                     bus.busy, bus.err, n_load);
        end
    endtask

    task automatic test_reset_mid_load();
        int n_load;
        n_load = 0;
        bus.sim_idle = 1'b1;
        bus.slot_sel = 4'd9;
        bus.load_req = 1'b1;
        tick();                                   // T+1 PAUSE
        bus.load_req = 1'b0;
        tick();                                   // T+2 LOAD_WAIT
        n_checks++;
        if (bus.sim_pause !== 1'b1 || bus.board_load !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_wait pause/load got=%b/%b want=1/0",
                     bus.sim_pause, bus.board_load);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus.busy, bus.sim_pause, bus.ram_wren, bus.board_load, bus.err} !== 5'b0
            || bus.err_code !== 2'd0 || bus.ram_addr !== 4'd0 || bus.slot_valid !== 16'h801F) begin
            n_fail++;
            $display("FAIL midload_reset ctrl/code/addr/valid got=%b/%0d/%0d/%h want=00000/0/0/801f",
                     {bus.busy, bus.sim_pause, bus.ram_wren, bus.board_load, bus.err},
                     bus.err_code, bus.ram_addr, bus.slot_valid);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.board_load) n_load++;
            tick();
        end
        n_checks++;
        if (n_load != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_after loads/busy got=%0d/%b want=0/0", n_load, bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_empty();
        test_save();
        test_load();
        test_back_to_back();
        test_preset_save();
        test_timeout();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/save_slot_controller.md
Name: save_slot_controller

Overview:
- Sequences user save/load requests against the save-slot RAM and preset decoder, which take a 4-bit slot address and a write enable, return decoded load values, and have registered RAM output.
- Pauses the generation engine, waits for it to go idle, then issues a one-cycle RAM write or a timed read followed by a one-cycle board-load strobe.
- Tracks which RAM slots hold valid saves and rejects illegal requests.
- Sits between the debounced key/switch inputs and the save manager / board engine.

Parameters:
- READ_LATENCY, 2, clock cycles from a stable ram_addr to valid load values at the board; range 1..7.
- PRESET_MASK, 16'h801F, bit n=1 means slot n is a fixed preset: read-only and always loadable.
- PAUSE_TIMEOUT, 255, max cycles to wait for sim_idle before aborting; range 1..65535.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- slot_sel  in  4  slot chosen by switches
- save_req  in  1  one-cycle save request pulse
- load_req  in  1  one-cycle load request pulse
- sim_idle  in  1  engine is between generations and paused
- sim_pause  out  1  request engine to stop stepping
- ram_addr  out  4  slot address to save manager (saveState)
- ram_wren  out  1  RAM write enable (save)
- board_load  out  1  one-cycle strobe: board latches load values
- busy  out  1  operation in progress; requests ignored
- err  out  1  one-cycle error pulse
- err_code  out  2  1 = save to preset, 2 = load of empty slot, 3 = pause timeout; holds until next err
- slot_valid  out  16  bit n=1 when slot n is loadable

Behaviour:
- Reset values:
  - state IDLE.
  - sim_pause, ram_wren, board_load, busy, err all 0.
  - err_code = 0; ram_addr = 0.
  - slot_valid = PRESET_MASK; internal RAM-valid bits cleared.
  - Counters cleared.
- Reset mid-operation aborts immediately to the reset values; a RAM write is never issued in the cycle reset is high.
- IDLE:
  - ram_addr <= slot_sel every cycle, so the preview follows the switches with 1-cycle lag.
  - save_req and load_req are sampled each cycle.
  - If both are high in the same cycle, save wins and load is dropped silently.
- Acceptance checks, in IDLE:
  - save_req with PRESET_MASK[slot_sel]=1: err=1 and err_code=1 next cycle; stay IDLE.
  - load_req with slot_valid[slot_sel]=0: err=1 and err_code=2 next cycle; stay IDLE.
  - Otherwise latch slot, op type and slot into ram_addr, and go to PAUSE. busy=1 and sim_pause=1 from the next cycle.
- While busy=1: ram_addr stays frozen; save_req, load_req and slot_sel are ignored (not queued).
- PAUSE:
  - Counts cycles.
  - sim_idle=1 sampled: go to SAVE_WR (save) or LOAD_WAIT (load).
  - Count reaches PAUSE_TIMEOUT without sim_idle: err=1, err_code=3, go to DONE. No write, no load.
- SAVE_WR: exactly one cycle.
  - ram_wren=1.
  - Set RAM-valid bit of the slot; the slot_valid bit reads 1 from the next cycle.
  - Go to DONE.
- LOAD_WAIT: READ_LATENCY cycles with ram_wren=0, then LOAD_APPLY.
- LOAD_APPLY: board_load=1 for exactly one cycle, then DONE.
- DONE: one cycle with sim_pause=0 and busy=1, then IDLE with busy=0.
- Invariants:
  - ram_wren and board_load are never high together.
  - Each is high only in its own state.
  - sim_pause=1 whenever ram_wren or board_load is 1.
- Save latency: request cycle T → sim_pause at T+1 → ram_wren at T+2 if sim_idle is already high at T+1.
- Load latency, with sim_idle high at T+1: board_load at T+2+READ_LATENCY; busy falls at T+4+READ_LATENCY.
- sim_idle dropping after PAUSE has been exited is ignored.
- slot_valid = PRESET_MASK | RAM-valid bits. Saving to an already-valid slot overwrites it; the bit stays 1.

Test Plan:
- Reset, then slot_sel=4'd7, load_req pulse → err=1 one cycle later, err_code=2, busy stays 0, slot_valid=16'h801F.
- slot_sel=7, save_req pulse, sim_idle tied 1 → sim_pause at T+1, ram_wren=1 at T+2 only with ram_addr=7, slot_valid=16'h809F at T+3, busy=0 at T+4.
- slot_sel=7, load_req pulse, sim_idle=1, READ_LATENCY=2 → board_load=1 only at T+4, ram_wren never 1, ram_addr=7 throughout, busy falls at T+6.
- Save and load pulsed in the same cycle on slot 9 → save executes, no board_load; a second save_req while busy → ignored, exactly one ram_wren.
- save_req on slot 0 → err_code=1, no sim_pause. With sim_idle=0 and PAUSE_TIMEOUT=4, load slot 15 → err_code=3 after 4 PAUSE cycles, no board_load, returns to IDLE.
- Assert reset during LOAD_WAIT → next cycle all outputs at reset values, RAM-valid bits cleared, no board_load afterwards.
